// File: rtl/tick_debounce.sv
// Multi-channel switch debouncer driven by a divided tick, with per-channel
// press/release pulses and a single-entry event queue with lowest-index priority.
module tick_debounce #(
  parameter int WIDTH        = 4,
  parameter int STABLE_TICKS = 20,
  localparam int CW  = $clog2(STABLE_TICKS + 1),
  localparam int CHW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             TICK_CLK,
  input  logic [WIDTH-1:0] BTN_IN,
  output logic [WIDTH-1:0] BTN_OUT,
  output logic [WIDTH-1:0] PRESS,
  output logic [WIDTH-1:0] RELEASE,
  output logic             EVT_VALID,
  input  logic             EVT_READY,
  output logic [CHW-1:0]   EVT_CH,
  output logic             EVT_PRESS,
  output logic             OVERFLOW
);

  logic             tick_q;
  logic [WIDTH-1:0] sync1, sync2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] btn_out_q, press_q, release_q;
  logic [WIDTH-1:0] pending, pend_type;
  logic             evt_valid_q, evt_press_q, overflow_q;
  logic [CHW-1:0]   evt_ch_q;

  logic             tick;
  logic [WIDTH-1:0] mismatch, accept;
  logic             load, found;
  logic [CHW-1:0]   sel_ch;
  logic [WIDTH-1:0] sel_onehot, load_sel;

  always_comb begin
    tick       = TICK_CLK & ~tick_q;
    mismatch   = sync2 ^ btn_out_q;
    accept     = '0;
    load       = ~evt_valid_q | EVT_READY;
    found      = 1'b0;
    sel_ch     = '0;
    sel_onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = tick & mismatch[i] & (cnt[i] == CW'(STABLE_TICKS - 1));
      // Lowest-index pending channel wins the event register.
      if (pending[i] && !found) begin
        found         = 1'b1;
        sel_ch        = CHW'(i);
        sel_onehot[i] = 1'b1;
      end
    end
    load_sel = sel_onehot & {WIDTH{load}};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_q      <= 1'b0;
      sync1       <= '0;
      sync2       <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      btn_out_q   <= '0;
      press_q     <= '0;
      release_q   <= '0;
      pending     <= '0;
      pend_type   <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_press_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      tick_q <= TICK_CLK;
      sync1  <= BTN_IN;
      sync2  <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (!mismatch[i] || accept[i]) cnt[i] <= '0;
        else if (tick)                 cnt[i] <= cnt[i] + 1'b1;
      end
      btn_out_q <= btn_out_q ^ accept;
      press_q   <= accept & ~btn_out_q;
      release_q <= accept & btn_out_q;

      // A channel being loaded this cycle can take a fresh change without loss.
      pending    <= (pending & ~load_sel) | accept;
      pend_type  <= (pend_type & ~accept) | (accept & ~btn_out_q);
      overflow_q <= overflow_q | (|(accept & pending & ~load_sel));

      if (load) begin
        if (found) begin
          evt_valid_q <= 1'b1;
          evt_ch_q    <= sel_ch;
          evt_press_q <= |(pend_type & sel_onehot);
        end else begin
          evt_valid_q <= 1'b0;
        end
      end
    end
  end

  assign BTN_OUT   = btn_out_q;
  assign PRESS     = press_q;
  assign RELEASE   = release_q;
  assign EVT_VALID = evt_valid_q;
  assign EVT_CH    = evt_ch_q;
  assign EVT_PRESS = evt_press_q;
  assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_tick_debounce.sv
// Directed bench for tick_debounce: debounce timing, bounce restart,
// event ordering, overflow and mid-run reset.
module tb_tick_debounce;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       TICK_CLK = 1'b0;
  logic       EVT_READY = 1'b0;
  logic [3:0] BTN_IN = 4'b0000;
  logic [3:0] BTN_OUT, PRESS, RELEASE;
  logic       EVT_VALID, EVT_PRESS, OVERFLOW;
  logic [1:0] EVT_CH;

  int checks = 0;
  int failures = 0;
  int press_cnt [4] = '{0, 0, 0, 0};

  tick_debounce #(.WIDTH(4), .STABLE_TICKS(20)) dut (
    .CLK(CLK), .RST_N(RST_N), .TICK_CLK(TICK_CLK), .BTN_IN(BTN_IN),
    .BTN_OUT(BTN_OUT), .PRESS(PRESS), .RELEASE(RELEASE),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_CH(EVT_CH),
    .EVT_PRESS(EVT_PRESS), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    for (int i = 0; i < 4; i++) if (PRESS[i] === 1'b1) press_cnt[i]++;

  // Raise TICK_CLK; returns just after the edge where the tick takes effect.
  task automatic tick_rise();
    @(negedge CLK) TICK_CLK = 1'b1;
    @(posedge CLK) #1;
  endtask

  task automatic tick_fall();
    repeat (3) @(posedge CLK);
    @(negedge CLK) TICK_CLK = 1'b0;
    repeat (4) @(posedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks += 7;
    if (BTN_OUT !== 4'b0) begin failures++; $display("FAIL rst_btn_out got=%b exp=0000", BTN_OUT); end
    if (PRESS !== 4'b0) begin failures++; $display("FAIL rst_press got=%b exp=0000", PRESS); end
    if (RELEASE !== 4'b0) begin failures++; $display("FAIL rst_release got=%b exp=0000", RELEASE); end
    if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL rst_evt_valid got=%b exp=0", EVT_VALID); end
    if (EVT_CH !== 2'd0) begin failures++; $display("FAIL rst_evt_ch got=%0d exp=0", EVT_CH); end
    if (EVT_PRESS !== 1'b0) begin failures++; $display("FAIL rst_evt_press got=%b exp=0", EVT_PRESS); end
    if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", OVERFLOW); end
    @(negedge CLK) RST_N = 1'b1;
  endtask

  task automatic test_single_press();
    int p0;
    logic [3:0] exp;
    p0 = press_cnt[0];
    @(negedge CLK) begin BTN_IN = 4'b0001; EVT_READY = 1'b0; end
    repeat (3) @(posedge CLK);
    for (int k = 1; k <= 20; k++) begin
      tick_rise();
      exp = (k == 20) ? 4'b0001 : 4'b0000;
      checks++;
      if (PRESS !== exp) begin failures++; $display("FAIL single_press tick=%0d got=%b exp=%b", k, PRESS, exp); end
      if (k < 20) tick_fall();
    end
    checks += 2;
    if (BTN_OUT !== 4'b0001) begin failures++; $display("FAIL single_btn_out got=%b exp=0001", BTN_OUT); end
    if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL single_evt_early got=%b exp=0", EVT_VALID); end
    @(posedge CLK) #1;
    checks += 4;
    if (EVT_VALID !== 1'b1) begin failures++; $display("FAIL single_evt_valid got=%b exp=1", EVT_VALID); end
    if (EVT_CH !== 2'd0) begin failures++; $display("FAIL single_evt_ch got=%0d exp=0", EVT_CH); end
    if (EVT_PRESS !== 1'b1) begin failures++; $display("FAIL single_evt_press got=%b exp=1", EVT_PRESS); end
    if (PRESS !== 4'b0) begin failures++; $display("FAIL single_press_width got=%b exp=0000", PRESS); end
    tick_fall();
    @(negedge CLK) EVT_READY = 1'b1;
    @(posedge CLK) #1;
    checks += 2;
    if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL single_evt_drain got=%b exp=0", EVT_VALID); end
    if (press_cnt[0] - p0 !== 1) begin failures++; $display("FAIL single_press_count got=%0d exp=1", press_cnt[0] - p0); end
    @(negedge CLK) EVT_READY = 1'b0;
  endtask

  task automatic test_bounce();
    int p1;
    logic [3:0] exp;
    p1 = press_cnt[1];
    @(negedge CLK) begin BTN_IN = 4'b0011; EVT_READY = 1'b1; end
    repeat (3) @(posedge CLK);
    for (int k = 1; k <= 5; k++) begin
      tick_rise();
      checks++;
      if (PRESS !== 4'b0) begin failures++; $display("FAIL bounce_early tick=%0d got=%b exp=0000", k, PRESS); end
      tick_fall();
    end
    @(negedge CLK) BTN_IN = 4'b0001;
    @(negedge CLK) BTN_IN = 4'b0011;
    repeat (3) @(posedge CLK);
    for (int k = 1; k <= 20; k++) begin
      tick_rise();
      exp = (k == 20) ? 4'b0010 : 4'b0000;
      checks++;
      if (PRESS !== exp) begin failures++; $display("FAIL bounce_press tick=%0d got=%b exp=%b", k, PRESS, exp); end
      if (k < 20) tick_fall();
    end
    @(posedge CLK) #1;
    checks += 3;
    if (EVT_VALID !== 1'b1) begin failures++; $display("FAIL bounce_evt_valid got=%b exp=1", EVT_VALID); end
    if (EVT_CH !== 2'd1) begin failures++; $display("FAIL bounce_evt_ch got=%0d exp=1", EVT_CH); end
    if (EVT_PRESS !== 1'b1) begin failures++; $display("FAIL bounce_evt_press got=%b exp=1", EVT_PRESS); end
    @(posedge CLK) #1;
    checks += 3;
    if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL bounce_evt_drain got=%b exp=0", EVT_VALID); end
    if (BTN_OUT !== 4'b0011) begin failures++; $display("FAIL bounce_btn_out got=%b exp=0011", BTN_OUT); end
    if (press_cnt[1] - p1 !== 1) begin failures++; $display("FAIL bounce_press_count got=%0d exp=1", press_cnt[1] - p1); end
    tick_fall();
  endtask

  task automatic test_same_tick();
    logic [3:0] ep, er;
    @(negedge CLK) begin BTN_IN = 4'b0110; EVT_READY = 1'b1; end
    repeat (3) @(posedge CLK);
    for (int k = 1; k <= 20; k++) begin
      tick_rise();
      ep = (k == 20) ? 4'b0100 : 4'b0000;
      er = (k == 20) ? 4'b0001 : 4'b0000;
      checks += 2;
      if (PRESS !== ep) begin failures++; $display("FAIL same_press tick=%0d got=%b exp=%b", k, PRESS, ep); end
      if (RELEASE !== er) begin failures++; $display("FAIL same_release tick=%0d got=%b exp=%b", k, RELEASE, er); end
      if (k < 20) tick_fall();
    end
    @(posedge CLK) #1;
    checks += 3;
    if (EVT_VALID !== 1'b1) begin failures++; $display("FAIL same_evt0_valid got=%b exp=1", EVT_VALID); end
    if (EVT_CH !== 2'd0) begin failures++; $display("FAIL same_evt0_ch got=%0d exp=0", EVT_CH); end
    if (EVT_PRESS !== 1'b0) begin failures++; $display("FAIL same_evt0_press got=%b exp=0", EVT_PRESS); end
    @(posedge CLK) #1;
    checks += 3;
    if (EVT_VALID !== 1'b1) begin failures++; $display("FAIL same_evt2_valid got=%b exp=1", EVT_VALID); end
    if (EVT_CH !== 2'd2) begin failures++; $display("FAIL same_evt2_ch got=%0d exp=2", EVT_CH); end
    if (EVT_PRESS !== 1'b1) begin failures++; $display("FAIL same_evt2_press got=%b exp=1", EVT_PRESS); end
    @(posedge CLK) #1;
    checks += 2;
    if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL same_evt_drain got=%b exp=0", EVT_VALID); end
    if (BTN_OUT !== 4'b0110) begin failures++; $display("FAIL same_btn_out got=%b exp=0110", BTN_OUT); end
    tick_fall();
  endtask

  task automatic test_overflow();
    logic [3:0] ep, er;
    @(negedge CLK) begin BTN_IN = 4'b1100; EVT_READY = 1'b0; end
    repeat (3) @(posedge CLK);
    for (int k = 1; k <= 20; k++) begin
      tick_rise();
      ep = (k == 20) ? 4'b1000 : 4'b0000;
      er = (k == 20) ? 4'b0010 : 4'b0000;
      checks += 2;
      if (PRESS !== ep) begin failures++; $display("FAIL ovf_press tick=%0d got=%b exp=%b", k, PRESS, ep); end
      if (RELEASE !== er) begin failures++; $display("FAIL ovf_release tick=%0d got=%b exp=%b", k, RELEASE, er); end
      if (k < 20) tick_fall();
    end
    @(posedge CLK) #1;
    checks += 3;
    if (EVT_VALID !== 1'b1 || EVT_CH !== 2'd1) begin failures++; $display("FAIL ovf_first_evt got=%b/%0d exp=1/1", EVT_VALID, EVT_CH); end
    if (EVT_PRESS !== 1'b0) begin failures++; $display("FAIL ovf_first_type got=%b exp=0", EVT_PRESS); end
    if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", OVERFLOW); end
    tick_fall();
    @(negedge CLK) BTN_IN = 4'b0100;
    repeat (3) @(posedge CLK);
    for (int k = 1; k <= 20; k++) begin
      tick_rise();
      er = (k == 20) ? 4'b1000 : 4'b0000;
      checks++;
      if (RELEASE !== er) begin failures++; $display("FAIL ovf_release3 tick=%0d got=%b exp=%b", k, RELEASE, er); end
      if (k < 20) tick_fall();
    end
    checks += 2;
    if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", OVERFLOW); end
    if (EVT_VALID !== 1'b1 || EVT_CH !== 2'd1 || EVT_PRESS !== 1'b0) begin
      failures++; $display("FAIL ovf_stall_hold got=%b/%0d/%b exp=1/1/0", EVT_VALID, EVT_CH, EVT_PRESS);
    end
    tick_fall();
    @(negedge CLK) EVT_READY = 1'b1;
    @(posedge CLK) #1;
    checks += 2;
    if (EVT_VALID !== 1'b1 || EVT_CH !== 2'd3) begin failures++; $display("FAIL ovf_evt3 got=%b/%0d exp=1/3", EVT_VALID, EVT_CH); end
    if (EVT_PRESS !== 1'b0) begin failures++; $display("FAIL ovf_evt3_type got=%b exp=0", EVT_PRESS); end
    @(negedge CLK) EVT_READY = 1'b0;
    @(posedge CLK) #1;
    checks++;
    if (EVT_VALID !== 1'b1 || EVT_CH !== 2'd3) begin failures++; $display("FAIL ovf_evt3_hold got=%b/%0d exp=1/3", EVT_VALID, EVT_CH); end
    @(negedge CLK) EVT_READY = 1'b1;
    @(posedge CLK) #1;
    checks += 2;
    if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL ovf_drain got=%b exp=0", EVT_VALID); end
    if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", OVERFLOW); end
    @(negedge CLK) EVT_READY = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    @(negedge CLK) BTN_IN = 4'b0101;
    repeat (3) @(posedge CLK);
    for (int k = 1; k <= 20; k++) begin
      tick_rise();
      exp = (k == 20) ? 4'b0001 : 4'b0000;
      checks++;
      if (PRESS !== exp) begin failures++; $display("FAIL mid_press tick=%0d got=%b exp=%b", k, PRESS, exp); end
      if (k < 20) tick_fall();
    end
    @(posedge CLK) #1;
    checks++;
    if (EVT_VALID !== 1'b1 || EVT_CH !== 2'd0) begin failures++; $display("FAIL mid_evt got=%b/%0d exp=1/0", EVT_VALID, EVT_CH); end
    tick_fall();
    @(negedge CLK) BTN_IN = 4'b0111;
    repeat (3) @(posedge CLK);
    for (int k = 1; k <= 10; k++) begin
      tick_rise();
      checks++;
      if (PRESS !== 4'b0) begin failures++; $display("FAIL mid_partial tick=%0d got=%b exp=0000", k, PRESS); end
      tick_fall();
    end
    @(negedge CLK) RST_N = 1'b0;
    #1;
    checks += 5;
    if (BTN_OUT !== 4'b0) begin failures++; $display("FAIL mid_rst_btn_out got=%b exp=0000", BTN_OUT); end
    if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL mid_rst_evt_valid got=%b exp=0", EVT_VALID); end
    if (EVT_CH !== 2'd0 || EVT_PRESS !== 1'b0) begin failures++; $display("FAIL mid_rst_evt got=%0d/%b exp=0/0", EVT_CH, EVT_PRESS); end
    if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL mid_rst_overflow got=%b exp=0", OVERFLOW); end
    if (PRESS !== 4'b0 || RELEASE !== 4'b0) begin failures++; $display("FAIL mid_rst_pulses got=%b/%b exp=0000/0000", PRESS, RELEASE); end
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    for (int k = 1; k <= 20; k++) begin
      tick_rise();
      exp = (k == 20) ? 4'b0111 : 4'b0000;
      checks++;
      if (PRESS !== exp) begin failures++; $display("FAIL mid_after_press tick=%0d got=%b exp=%b", k, PRESS, exp); end
      if (k < 20) tick_fall();
    end
    @(posedge CLK) #1;
    checks += 2;
    if (EVT_VALID !== 1'b1 || EVT_CH !== 2'd0 || EVT_PRESS !== 1'b1) begin
      failures++; $display("FAIL mid_after_evt got=%b/%0d/%b exp=1/0/1", EVT_VALID, EVT_CH, EVT_PRESS);
    end
    if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL mid_after_overflow got=%b exp=0", OVERFLOW); end
    tick_fall();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_same_tick();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
